alu_issue_reg: RTL
==================

# alu_issue_reg

ID/EX pipeline register that feeds the 32-bit ALU. Captures decoded operands, immediate and 3-bit ALU control from decode, resolves RAW hazards by forwarding from the MEM and WB stages, and presents registered `a`, `b` and `control` to the ALU together with destination tag and write-enable for downstream stages. Supports hazard-unit stall and branch/exception flush, and refreshes held operands from forwarding paths while stalled.

## Interface
Parameters:
- `RW`, 5, register-address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents a valid instruction.
- `in_ready`  out  1  stage accepts; equals `!stall`.
- `in_rs_data`, `in_rt_data`  in  32  register-file read data.
- `in_imm`  in  32  sign/zero-extended immediate.
- `in_rs`, `in_rt`, `in_rd`  in  RW  source and destination tags.
- `in_alusrc`  in  1  1 selects `in_imm` for `b`.
- `in_control`  in  3  ALU control code.
- `in_regwrite`  in  1  instruction writes `in_rd`.
- `stall`  in  1  hold current contents.
- `flush`  in  1  kill current contents.
- `mem_we`, `mem_rd`, `mem_data`  in  1/RW/32  MEM-stage forwarding source.
- `wb_we`, `wb_rd`, `wb_data`  in  1/RW/32  WB-stage forwarding source.
- `out_valid`  out  1  registered instruction valid.
- `out_a`, `out_b`  out  32  ALU operands.
- `out_control`  out  3  ALU control.
- `out_rd`  out  RW  destination tag.
- `out_regwrite`  out  1  gated: `out_valid & held regwrite`.

## Operation
- Forward select per source `s` (rs or rt), tag `t`: if `mem_we & mem_rd==t & t!=0` → `mem_data`; else if `wb_we & wb_rd==t & t!=0` → `wb_data`; else register-file data. MEM has priority over WB. Register 0 is never forwarded.
- `b` = `in_imm` when `in_alusrc=1`, else forwarded rt.
- Update priority each edge: `flush` > `stall` > capture.
  - `flush=1`: `out_valid`←0, `out_regwrite`←0; data fields unchanged. Flush overrides stall.
  - `stall=1`, no flush: all fields held, except held `out_a` (and `out_b` when held alusrc=0) are reloaded if the held rs/rt tag matches an enabled MEM/WB forward source, same priority rules.
  - otherwise: `out_valid`←`in_valid`; all fields loaded from inputs (forwarded); fields loaded even when `in_valid=0`, with `out_regwrite` forced 0.
- Held stage stores rs, rt and alusrc internally to support stall refresh.

## Timing
- One-cycle latency: inputs at edge N appear on outputs after edge N.
- Forward muxes combinational from `mem_*`/`wb_*` to capture registers; no comb path to outputs.
- `in_ready` combinational from `stall` only.
- Reset (async assert, sync-to-clock deassert by system): `out_valid`=0, `out_a`=`out_b`=0, `out_control`=3'b000, `out_rd`=0, `out_regwrite`=0, internal tags 0.
- Simultaneous `stall` and `flush`: flush wins; bubble inserted.
- Reset mid-stall: all state cleared; no held instruction survives.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding on capture and stall refresh as above.
- Undefined: operands taken directly from `in_rs_data`/`in_rt_data`/`in_imm`; no stall refresh; `mem_*`/`wb_*` ignored; hazard unit must stall until writeback.

## Test plan
- Reset: `rst_n`=0 mid-run → all outputs 0 immediately, before next edge.
- Plain capture: rs_data=5, rt_data=7, alusrc=0, control=3'b010, rd=3, regwrite=1 → next cycle `out_a`=5, `out_b`=7, `out_control`=010, `out_regwrite`=1.
- Forward priority: rs=4, mem_rd=4 data 0x11, wb_rd=4 data 0x22 → `out_a`=0x11; mem_we=0 → 0x22; rs=0 with mem_rd=0 → register-file value.
- Stall refresh: held rt=6, alusrc=0, stall=1, wb_we=1 wb_rd=6 data 0xABCD → `out_b`=0xABCD next cycle, `out_valid` stays 1; alusrc=1 → `out_b` unchanged.
- Flush vs stall: stall=1 and flush=1 together → `out_valid`=0, `out_regwrite`=0; `in_ready`=0.
- Macro off: mem_rd matches rs with data 0x99 → `out_a` equals `in_rs_data`, not 0x99.

Source files
------------

// File: rtl/alu_issue_reg.sv
// ID/EX issue register feeding the 32-bit ALU, with MEM/WB forwarding when ALU_ISSUE_FWD_EN is defined.
// Latency: one cycle from decode inputs to registered ALU operands and control; no combinational path to outputs.
// Backpressure: stall holds contents (in_ready = !stall); flush inserts a bubble and overrides stall.
module alu_issue_reg #(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_rs_data,
    input  logic [31:0]   in_rt_data,
    input  logic [31:0]   in_imm,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    input  logic          in_alusrc,
    input  logic [2:0]    in_control,
    input  logic          in_regwrite,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_we,
    input  logic [RW-1:0] mem_rd,
    input  logic [31:0]   mem_data,
    input  logic          wb_we,
    input  logic [RW-1:0] wb_rd,
    input  logic [31:0]   wb_data,
    output logic          out_valid,
    output logic [31:0]   out_a,
    output logic [31:0]   out_b,
    output logic [2:0]    out_control,
    output logic [RW-1:0] out_rd,
    output logic          out_regwrite
);

    logic          valid_q, valid_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic          alusrc_q, alusrc_d;

    logic [31:0]   cap_a;
    logic [31:0]   cap_rt;

`ifdef ALU_ISSUE_FWD_EN
    // MEM beats WB; register 0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [RW-1:0] tag,
        input logic [31:0]   dflt,
        input logic          m_we,
        input logic [RW-1:0] m_rd,
        input logic [31:0]   m_data,
        input logic          w_we,
        input logic [RW-1:0] w_rd,
        input logic [31:0]   w_data
    );
        logic [31:0] r;
        r = dflt;
        if (tag != '0) begin
            if (m_we && (m_rd == tag))      r = m_data;
            else if (w_we && (w_rd == tag)) r = w_data;
        end
        return r;
    endfunction

    assign cap_a  = fwd_sel(in_rs, in_rs_data, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
    assign cap_rt = fwd_sel(in_rt, in_rt_data, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
`else
    // Without forwarding the hazard unit stalls until writeback, so the
    // register-file data is already current; held tags are kept only for
    // structural symmetry with the forwarding build.
    assign cap_a  = in_rs_data;
    assign cap_rt = in_rt_data;

    logic unused_fwd;
    assign unused_fwd = ^{mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, rs_q, rt_q};
`endif

    assign in_ready = !stall;

    // Next state: flush beats stall beats capture.
    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        alusrc_d   = alusrc_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (stall) begin
`ifdef ALU_ISSUE_FWD_EN
            // A producer may reach MEM/WB while we wait; pick up its result.
            a_d = fwd_sel(rs_q, a_q, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
            if (!alusrc_q)
                b_d = fwd_sel(rt_q, b_q, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
`endif
        end else begin
            valid_d    = in_valid;
            a_d        = cap_a;
            b_d        = in_alusrc ? in_imm : cap_rt;
            ctrl_d     = in_control;
            rd_d       = in_rd;
            regwrite_d = in_valid & in_regwrite;
            rs_d       = in_rs;
            rt_d       = in_rt;
            alusrc_d   = in_alusrc;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= 3'b000;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            alusrc_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            alusrc_q   <= alusrc_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_a        = a_q;
    assign out_b        = b_q;
    assign out_control  = ctrl_q;
    assign out_rd       = rd_q;
    assign out_regwrite = valid_q & regwrite_q;

endmodule
